// File: rtl/ps2_key_receiver_if.sv
// ps2_key_receiver_if: PS/2 pins in, decoded byte/error/key levels out
interface ps2_key_receiver_if #(parameter int NUM_KEYS = 2);
  logic                kb_clock;
  logic                kb_data;
  logic [7:0]          scan_code;
  logic                code_valid;
  logic                parity_error;
  logic                frame_error;
  logic [NUM_KEYS-1:0] key_held;
  modport master (output kb_clock, kb_data, input scan_code, code_valid, parity_error, frame_error, key_held);
  modport slave (input kb_clock, kb_data, output scan_code, code_valid, parity_error, frame_error, key_held);
endinterface

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: oversampled PS/2 deframer with parity/stop/timeout checks and E0/F0 key decode
module ps2_key_receiver #(
  parameter int                        NUM_KEYS       = 2,
  parameter logic [8*NUM_KEYS-1:0]     KEY_CODES      = 16'h7275,
  parameter logic [NUM_KEYS-1:0]       KEY_EXT        = 2'b11,
  parameter int                        TIMEOUT_CYCLES = 100000
) (
  input logic              sys_clock,
  input logic              reset,
  ps2_key_receiver_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t              state;
  logic                kc_s1, kc_s2, kc_prev, kd_s1, kd_s2;
  logic [2:0]          bit_cnt;
  logic [7:0]          sh;
  logic                par;
  logic [TW-1:0]       tmo;
  logic                ext_p, brk_p;
  logic [7:0]          scan_code;
  logic                code_valid, parity_error, frame_error;
  logic [NUM_KEYS-1:0] key_held;
  logic                fall;
  assign fall = kc_prev & ~kc_s2;
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      {kc_s1, kc_s2, kc_prev, kd_s1, kd_s2} <= '1;
      bit_cnt      <= '0;
      sh           <= '0;
      par          <= 1'b0;
      tmo          <= '0;
      ext_p        <= 1'b0;
      brk_p        <= 1'b0;
      scan_code    <= '0;
      code_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      key_held     <= '0;
    end else begin
      kc_s1        <= bus.kb_clock;
      kc_s2        <= kc_s1;
      kc_prev      <= kc_s2;
      kd_s1        <= bus.kb_data;
      kd_s2        <= kd_s1;
      code_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      tmo          <= (state == IDLE || fall) ? '0 : tmo + 1'b1;
      if (fall) begin
        case (state)
          IDLE: if (!kd_s2) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            sh      <= {kd_s2, sh[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= kd_s2;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            // a bad stop bit outranks a bad parity bit
            if (!kd_s2 || !(^{sh, par})) begin
              frame_error  <= !kd_s2;
              parity_error <= kd_s2;
              ext_p        <= 1'b0;
              brk_p        <= 1'b0;
            end else begin
              scan_code  <= sh;
              code_valid <= 1'b1;
              if (sh == 8'hE0) ext_p <= 1'b1;
              else if (sh == 8'hF0) brk_p <= 1'b1;
              else begin
                for (int i = 0; i < NUM_KEYS; i++)
                  if (sh == KEY_CODES[8*i +: 8] && ext_p == KEY_EXT[i]) key_held[i] <= ~brk_p;
                ext_p <= 1'b0;
                brk_p <= 1'b0;
              end
            end
          end
        endcase
      end else if (state != IDLE && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
        state       <= IDLE;
        frame_error <= 1'b1;
        ext_p       <= 1'b0;
        brk_p       <= 1'b0;
      end
    end
  end
  assign bus.scan_code    = scan_code;
  assign bus.code_valid   = code_valid;
  assign bus.parity_error = parity_error;
  assign bus.frame_error  = frame_error;
  assign bus.key_held     = key_held;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: scenario tasks plus randomized frames against a byte-level key model
module tb_ps2_key_receiver;
  localparam int NK = 2;
  localparam int TO = 200;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ps2_key_receiver_if #(.NUM_KEYS(NK)) bus ();
  ps2_key_receiver #(.NUM_KEYS(NK), .KEY_CODES(16'h7275), .KEY_EXT(2'b11), .TIMEOUT_CYCLES(TO))
    dut (.sys_clock(clk), .reset(rst), .bus(bus));
  int checks = 0, failures = 0;
  int cv_n = 0, pe_n = 0, fe_n = 0, excl_n = 0;
  int d_cv, d_pe, d_fe, e_cv, e_pe, e_fe;
  logic [7:0] codes [NK] = '{8'h75, 8'h72};
  logic       exts  [NK] = '{1'b1, 1'b1};
  logic       ext_m = 1'b0, brk_m = 1'b0;
  logic [NK-1:0] keys_m = '0;
  logic [7:0] code_m = 8'h00;
  always @(negedge clk) begin
    if (bus.code_valid) cv_n++;
    if (bus.parity_error) pe_n++;
    if (bus.frame_error) fe_n++;
    if (int'(bus.code_valid) + int'(bus.parity_error) + int'(bus.frame_error) > 1) excl_n++;
  end
  task automatic send_bit(input logic b);
    bus.kb_data = b;
    #200 bus.kb_clock = 1'b0;
    #200 bus.kb_clock = 1'b1;
  endtask
  task automatic model(input logic [7:0] b, input logic bad_par, input logic stop);
    e_cv = 0; e_pe = 0; e_fe = 0;
    if (!stop || bad_par) begin
      e_fe = !stop; e_pe = stop; ext_m = 0; brk_m = 0;
    end else begin
      e_cv = 1; code_m = b;
      if (b == 8'hE0) ext_m = 1;
      else if (b == 8'hF0) brk_m = 1;
      else begin
        for (int k = 0; k < NK; k++) if (b == codes[k] && ext_m == exts[k]) keys_m[k] = !brk_m;
        ext_m = 0; brk_m = 0;
      end
    end
  endtask
  task automatic xfer(input logic [7:0] b, input logic bad_par, input logic stop);
    int c0 = cv_n, p0 = pe_n, f0 = fe_n;
    model(b, bad_par, stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    send_bit(stop);
    bus.kb_data = 1'b1;
    d_cv = cv_n - c0; d_pe = pe_n - p0; d_fe = fe_n - f0;
  endtask
  task automatic test_reset;
    #33;
    checks++; if (bus.scan_code !== 8'h00) begin failures++; $display("FAIL reset_scan got=%h exp=00", bus.scan_code); end
    checks++; if (bus.key_held !== 2'b00) begin failures++; $display("FAIL reset_keys got=%b exp=00", bus.key_held); end
    checks++; if ({bus.code_valid, bus.parity_error, bus.frame_error} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {bus.code_valid, bus.parity_error, bus.frame_error}); end
    rst = 1'b0;
    #200;
    checks++; if (cv_n + pe_n + fe_n !== 0) begin failures++; $display("FAIL idle_pulses got=%0d exp=0", cv_n + pe_n + fe_n); end
  endtask
  task automatic test_basic;
    xfer(8'h1C, 1'b0, 1'b1);
    checks++; if (d_cv !== 1) begin failures++; $display("FAIL basic_cv got=%0d exp=1", d_cv); end
    checks++; if (bus.scan_code !== 8'h1C) begin failures++; $display("FAIL basic_scan got=%h exp=1c", bus.scan_code); end
    checks++; if (d_pe + d_fe !== 0) begin failures++; $display("FAIL basic_err got=%0d exp=0", d_pe + d_fe); end
    checks++; if (bus.key_held !== 2'b00) begin failures++; $display("FAIL basic_keys got=%b exp=00", bus.key_held); end
  endtask
  task automatic test_key_sequence;
    logic [7:0] seq [9] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h72, 8'h00, 8'h00};
    logic [1:0] exp_after [9] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    for (int i = 0; i < 7; i++) begin
      xfer(seq[i], 1'b0, 1'b1);
      checks++; if (d_cv !== 1) begin failures++; $display("FAIL seq_cv[%0d] got=%0d exp=1", i, d_cv); end
      checks++; if (bus.key_held !== exp_after[i]) begin failures++; $display("FAIL seq_keys[%0d] got=%b exp=%b", i, bus.key_held, exp_after[i]); end
    end
  endtask
  task automatic test_bare;
    xfer(8'h75, 1'b0, 1'b1);
    checks++; if (d_cv !== 1 || bus.scan_code !== 8'h75) begin failures++; $display("FAIL bare_cv got=%0d/%h exp=1/75", d_cv, bus.scan_code); end
    checks++; if (bus.key_held !== 2'b10) begin failures++; $display("FAIL bare_keys got=%b exp=10", bus.key_held); end
  endtask
  task automatic test_parity;
    xfer(8'hE0, 1'b0, 1'b1);
    xfer(8'h75, 1'b1, 1'b1);
    checks++; if (d_pe !== 1 || d_cv !== 0 || d_fe !== 0) begin failures++; $display("FAIL parity_pulses got=pe%0d cv%0d fe%0d exp=pe1 cv0 fe0", d_pe, d_cv, d_fe); end
    checks++; if (bus.scan_code !== 8'hE0) begin failures++; $display("FAIL parity_scan_hold got=%h exp=e0", bus.scan_code); end
    xfer(8'h75, 1'b0, 1'b1);
    checks++; if (bus.key_held !== 2'b10) begin failures++; $display("FAIL parity_flag_clear got=%b exp=10", bus.key_held); end
    xfer(8'hE0, 1'b0, 1'b1);
    xfer(8'h75, 1'b0, 1'b1);
    checks++; if (bus.key_held !== 2'b11) begin failures++; $display("FAIL parity_recover got=%b exp=11", bus.key_held); end
  endtask
  task automatic test_stop_error;
    xfer(8'hE0, 1'b0, 1'b1);
    xfer(8'hF0, 1'b1, 1'b0);
    checks++; if (d_fe !== 1 || d_pe !== 0 || d_cv !== 0) begin failures++; $display("FAIL stop_pulses got=fe%0d pe%0d cv%0d exp=fe1 pe0 cv0", d_fe, d_pe, d_cv); end
    xfer(8'h72, 1'b0, 1'b1);
    checks++; if (bus.key_held !== 2'b11) begin failures++; $display("FAIL stop_flag_clear got=%b exp=11", bus.key_held); end
  endtask
  task automatic test_timeout;
    int f0;
    xfer(8'hE0, 1'b0, 1'b1);
    f0 = fe_n;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    #1500;
    checks++; if (fe_n - f0 !== 0) begin failures++; $display("FAIL timeout_early got=%0d exp=0", fe_n - f0); end
    #1500;
    checks++; if (fe_n - f0 !== 1) begin failures++; $display("FAIL timeout_abort got=%0d exp=1", fe_n - f0); end
    ext_m = 0; brk_m = 0;
    xfer(8'h1C, 1'b0, 1'b1);
    checks++; if (d_cv !== 1 || d_fe !== 0 || bus.scan_code !== 8'h1C) begin failures++; $display("FAIL timeout_next got=cv%0d fe%0d %h exp=cv1 fe0 1c", d_cv, d_fe, bus.scan_code); end
    xfer(8'h72, 1'b0, 1'b1);
    checks++; if (bus.key_held !== keys_m) begin failures++; $display("FAIL timeout_flag_clear got=%b exp=%b", bus.key_held, keys_m); end
  endtask
  task automatic test_reset_midframe;
    int c0, p0, f0;
    xfer(8'hE0, 1'b0, 1'b1);
    xfer(8'h75, 1'b0, 1'b1);
    checks++; if (bus.key_held[0] !== 1'b1) begin failures++; $display("FAIL pre_reset_key got=%b exp=1", bus.key_held[0]); end
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    #50 rst = 1'b1;
    #1;
    checks++; if ({bus.scan_code, bus.key_held} !== 10'd0) begin failures++; $display("FAIL async_reset got=%h/%b exp=00/00", bus.scan_code, bus.key_held); end
    #19 rst = 1'b0;
    keys_m = '0; ext_m = 0; brk_m = 0; code_m = 8'h00;
    c0 = cv_n; p0 = pe_n; f0 = fe_n;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    #3000;
    checks++; if (cv_n - c0 + pe_n - p0 + fe_n - f0 !== 0) begin failures++; $display("FAIL reset_tail_ignored got=%0d exp=0", cv_n - c0 + pe_n - p0 + fe_n - f0); end
    xfer(8'hE0, 1'b0, 1'b1);
    xfer(8'h75, 1'b0, 1'b1);
    checks++; if (bus.key_held !== 2'b01) begin failures++; $display("FAIL post_reset_keys got=%b exp=01", bus.key_held); end
  endtask
  task automatic test_random;
    logic [7:0] pool [6] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h1C, 8'h00};
    logic [7:0] b;
    logic bp, st;
    for (int n = 0; n < 60; n++) begin
      b = pool[$urandom_range(0, 5)];
      if (b == 8'h00) b = 8'($urandom);
      bp = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 11) != 0);
      xfer(b, bp, st);
      checks++; if (d_cv !== e_cv || d_pe !== e_pe || d_fe !== e_fe) begin failures++; $display("FAIL rand_pulses[%0d] b=%h got=%0d%0d%0d exp=%0d%0d%0d", n, b, d_cv, d_pe, d_fe, e_cv, e_pe, e_fe); end
      checks++; if (bus.scan_code !== code_m) begin failures++; $display("FAIL rand_scan[%0d] got=%h exp=%h", n, bus.scan_code, code_m); end
      checks++; if (bus.key_held !== keys_m) begin failures++; $display("FAIL rand_keys[%0d] got=%b exp=%b", n, bus.key_held, keys_m); end
    end
  endtask
  task automatic test_exclusive;
    checks++; if (excl_n !== 0) begin failures++; $display("FAIL exclusive_pulses got=%0d exp=0", excl_n); end
  endtask
  initial begin
    bus.kb_clock = 1'b1;
    bus.kb_data  = 1'b1;
    test_reset;
    test_basic;
    test_key_sequence;
    test_bare;
    test_parity;
    test_stop_error;
    test_timeout;
    test_reset_midframe;
    test_random;
    test_exclusive;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
